// File: rtl/elevator_request_scheduler.sv
// LOOK-policy elevator scheduler: latches car/hall calls, owns floor and direction, times the door.
// Optional feature macro SCHED_DOOR_REOPEN_EN: a hold or servable call during DOOR_CLOSE reopens the door.
module elevator_request_scheduler #(
  parameter int N_FLOORS    = 6,
  parameter int FLOOR_W     = 3,
  parameter int MOVE_TICKS  = 2,
  parameter int DOOR_TICKS  = 3,
  parameter int CLOSE_TICKS = 1
) (
  input  logic                clk_50M,
  input  logic                rst,
  input  logic                tick,
  input  logic [N_FLOORS-1:0] req_in_set,
  input  logic [N_FLOORS-1:0] req_up_set,
  input  logic [N_FLOORS-1:0] req_down_set,
  input  logic                door_hold,
  output logic [N_FLOORS-1:0] pend_in,
  output logic [N_FLOORS-1:0] pend_up,
  output logic [N_FLOORS-1:0] pend_down,
  output logic [FLOOR_W-1:0]  cur_floor,
  output logic [1:0]          direction,
  output logic                moving,
  output logic                door_open,
  output logic                door_closing
);
  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DOOR_OPEN, S_DOOR_CLOSE} state_t;
  localparam logic [1:0] DIR_IDLE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;
  localparam int MAX_T_A = (MOVE_TICKS > DOOR_TICKS) ? MOVE_TICKS : DOOR_TICKS;
  localparam int MAX_T   = (MAX_T_A > CLOSE_TICKS) ? MAX_T_A : CLOSE_TICKS;
  localparam int CNT_W   = ($clog2(MAX_T) < 1) ? 1 : $clog2(MAX_T);
  localparam logic [N_FLOORS-1:0] ONE_HOT0 = {{(N_FLOORS-1){1'b0}}, 1'b1};
`ifdef SCHED_DOOR_REOPEN_EN
  localparam bit REOPEN_EN = 1'b1;
`else
  localparam bit REOPEN_EN = 1'b0;
`endif

  state_t              r_state;
  logic [N_FLOORS-1:0] r_pend_in, r_pend_up, r_pend_down;
  logic [FLOOR_W-1:0]  r_floor;
  logic [1:0]          r_dir;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_moving, r_door_open, r_door_closing;

  logic [N_FLOORS-1:0] w_set_up, w_set_down, w_cur_hot;
  logic [N_FLOORS-1:0] w_blk_in, w_blk_up, w_blk_down;
  logic [N_FLOORS-1:0] w_in, w_up, w_down, w_all, w_eval_hot;
  logic [N_FLOORS-1:0] w_clr_in, w_clr_up, w_clr_down;
  logic [FLOOR_W-1:0]  w_next_floor, w_eval_floor;
  logic [1:0]          w_svc_dir;
  logic                w_here_pulse, w_reopen, w_suppress, w_step;
  logic                w_above, w_below, w_here_any, w_ahead, w_stop;

  // Request latching: calls that the open (or reopening) door would serve are swallowed.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    w_set_up                 = req_up_set;
    w_set_up[N_FLOORS-1]     = 1'b0;
    w_set_down               = req_down_set;
    w_set_down[0]            = 1'b0;
    w_cur_hot                = ONE_HOT0 << r_floor;
    w_blk_in                 = req_in_set & w_cur_hot;
    w_blk_up                 = (r_dir != DIR_DOWN) ? (w_set_up & w_cur_hot) : '0;
    w_blk_down               = (r_dir != DIR_UP) ? (w_set_down & w_cur_hot) : '0;
    w_here_pulse             = |(w_blk_in | w_blk_up | w_blk_down);
    w_reopen                 = REOPEN_EN && (r_state == S_DOOR_CLOSE) && (door_hold || w_here_pulse);
    w_suppress               = (r_state == S_DOOR_OPEN) || w_reopen;
    w_in                     = r_pend_in   | (req_in_set & ~(w_suppress ? w_blk_in : '0));
    w_up                     = r_pend_up   | (w_set_up   & ~(w_suppress ? w_blk_up : '0));
    w_down                   = r_pend_down | (w_set_down & ~(w_suppress ? w_blk_down : '0));
    w_all                    = w_in | w_up | w_down;
  end

  // Floor evaluation: the arrival floor during a step, otherwise the current floor.
  always_comb begin
    w_step       = (r_state == S_MOVE) && tick && (r_cnt == CNT_W'(MOVE_TICKS - 1));
    w_next_floor = r_floor;
    if (r_dir == DIR_UP && r_floor != FLOOR_W'(N_FLOORS - 1))
      w_next_floor = r_floor + FLOOR_W'(1);
    else if (r_dir == DIR_DOWN && r_floor != '0)
      w_next_floor = r_floor - FLOOR_W'(1);
    w_eval_floor = w_step ? w_next_floor : r_floor;
    w_eval_hot   = ONE_HOT0 << w_eval_floor;
    w_above      = 1'b0;
    w_below      = 1'b0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (i > int'(w_eval_floor)) w_above = w_above | w_all[i];
      if (i < int'(w_eval_floor)) w_below = w_below | w_all[i];
    end
    w_here_any = |(w_all & w_eval_hot);
    w_ahead    = (r_dir == DIR_UP && w_above) || (r_dir == DIR_DOWN && w_below);
    w_stop     = (|(w_in & w_eval_hot)) ||
                 (r_dir == DIR_UP && |(w_up & w_eval_hot)) ||
                 (r_dir == DIR_DOWN && |(w_down & w_eval_hot)) ||
                 (!w_ahead && w_here_any);
    w_svc_dir = DIR_IDLE;
    case (r_dir)
      DIR_DOWN: w_svc_dir = w_below ? DIR_DOWN : (w_above ? DIR_UP : DIR_IDLE);
      default:  w_svc_dir = w_above ? DIR_UP : (w_below ? DIR_DOWN : DIR_IDLE);
    endcase
    w_clr_in   = w_eval_hot;
    w_clr_up   = (w_svc_dir != DIR_DOWN) ? w_eval_hot : '0;
    w_clr_down = (w_svc_dir != DIR_UP) ? w_eval_hot : '0;
  end

  always_ff @(posedge clk_50M) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_state        <= S_IDLE;
      r_pend_in      <= '0;
      r_pend_up      <= '0;
      r_pend_down    <= '0;
      r_floor        <= '0;
      r_dir          <= DIR_IDLE;
      r_cnt          <= '0;
      r_moving       <= 1'b0;
      r_door_open    <= 1'b0;
      r_door_closing <= 1'b0;
    end else begin
      r_pend_in   <= w_in;
      r_pend_up   <= w_up;
      r_pend_down <= w_down;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_here_any) begin
            r_state     <= S_DOOR_OPEN;
            r_door_open <= 1'b1;
            r_dir       <= w_svc_dir;
            r_pend_in   <= w_in & ~w_clr_in;
            r_pend_up   <= w_up & ~w_clr_up;
            r_pend_down <= w_down & ~w_clr_down;
          end else if (w_above) begin
            r_state  <= S_MOVE;
            r_moving <= 1'b1;
            r_dir    <= DIR_UP;
          end else if (w_below) begin
            r_state  <= S_MOVE;
            r_moving <= 1'b1;
            r_dir    <= DIR_DOWN;
          end else begin
            r_dir <= DIR_IDLE;
          end
        end
        S_MOVE: begin
          if (w_step) begin
            r_cnt   <= '0;
            r_floor <= w_next_floor;
            if (w_stop) begin
              r_state     <= S_DOOR_OPEN;
              r_moving    <= 1'b0;
              r_door_open <= 1'b1;
              r_dir       <= w_svc_dir;
              r_pend_in   <= w_in & ~w_clr_in;
              r_pend_up   <= w_up & ~w_clr_up;
              r_pend_down <= w_down & ~w_clr_down;
            end else if (!(|w_all)) begin
              r_state  <= S_IDLE;
              r_moving <= 1'b0;
              r_dir    <= DIR_IDLE;
            end else if (!w_ahead) begin
              r_dir <= (r_dir == DIR_UP) ? DIR_DOWN : DIR_UP;
            end
          end else if (tick) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DOOR_OPEN: begin
          if (door_hold || w_here_pulse) begin
            r_cnt <= '0;
          end else if (tick) begin
            if (r_cnt == CNT_W'(DOOR_TICKS - 1)) begin
              r_cnt          <= '0;
              r_state        <= S_DOOR_CLOSE;
              r_door_open    <= 1'b0;
              r_door_closing <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        S_DOOR_CLOSE: begin
          if (w_reopen) begin
            r_cnt          <= '0;
            r_state        <= S_DOOR_OPEN;
            r_door_closing <= 1'b0;
            r_door_open    <= 1'b1;
          end else if (tick) begin
            if (r_cnt == CNT_W'(CLOSE_TICKS - 1)) begin
              r_cnt          <= '0;
              r_state        <= S_IDLE;
              r_door_closing <= 1'b0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pend_in      = r_pend_in;
  assign pend_up      = r_pend_up;
  assign pend_down    = r_pend_down;
  assign cur_floor    = r_floor;
  assign direction    = r_dir;
  assign moving       = r_moving;
  assign door_open    = r_door_open;
  assign door_closing = r_door_closing;
endmodule
